// File: rtl/fifo_burst_rd_ctrl.sv
// fifo_burst_rd_ctrl
// Reads video words out of a line FIFO in bursts and hands them to a pSRAM
// writer. Each burst is requested with wr_req/wr_ack, then the FIFO is read
// until wr_len words have been issued, with stalls while the FIFO is empty.
// Bursts advance a pSRAM word address and a line word count. line_done pulses
// once per completed line.
//
// Optional feature: define RD_CTRL_UNDERFLOW_CNT_EN to add underflow_cnt_o, a
// saturating count of burst cycles stalled on an empty FIFO.
//
// Ports
//   rclk_i            sole clock, rising edge
//   reset_i           asynchronous active-high reset (release synchronised)
//   en_i              run enable (level)
//   frame_start_i     clears address and line count while IDLE/WAIT
//   fifo_rdata_i      FIFO read data, valid the cycle after fifo_ren_o
//   fifo_rempty_i     FIFO empty
//   fifo_prog_empty_i FIFO below burst threshold
//   fifo_ren_o        FIFO read enable
//   wr_req_o/wr_ack_i burst request / grant
//   wr_addr_o         burst start word address
//   wr_len_o          burst word count
//   wr_data_o         burst data beat
//   wr_valid_o        burst data beat valid
//   line_done_o       one-cycle pulse per completed line
//   busy_o            controller not idle
//   underflow_cnt_o   (optional) stalled burst cycle count
module fifo_burst_rd_ctrl #(
  parameter int BURST_LEN  = 64,
  parameter int LINE_WORDS = 480,
  parameter int ADDR_W     = 24
) (
  input  logic              rclk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic              frame_start_i,
  input  logic [31:0]       fifo_rdata_i,
  input  logic              fifo_rempty_i,
  input  logic              fifo_prog_empty_i,
  output logic              fifo_ren_o,
  output logic              wr_req_o,
  input  logic              wr_ack_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [8:0]        wr_len_o,
  output logic [31:0]       wr_data_o,
  output logic              wr_valid_o,
  output logic              line_done_o,
  output logic              busy_o
`ifdef RD_CTRL_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]       underflow_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT     = 3'd1,
    S_REQ      = 3'd2,
    S_BURST    = 3'd3,
    S_DRAIN    = 3'd4,
    S_LINE_END = 3'd5
  } state_t;

  localparam logic [11:0] LINE_WORDS_C = 12'(LINE_WORDS);
  localparam logic [8:0]  BURST_LEN_C  = 9'(BURST_LEN);

  state_t              state_q;
  logic [1:0]          rst_sync_q;
  logic                rst_s;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [8:0]          wr_len_q;
  logic [8:0]          rem_q;
  logic [11:0]         line_cnt_q;
  logic                wr_req_q;
  logic                wr_valid_q;
  logic                line_done_q;
  logic [11:0]         line_left_s;
  logic [8:0]          burst_len_s;
  logic [11:0]         line_cnt_d;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic                fifo_ren_s;
`ifdef RD_CTRL_UNDERFLOW_CNT_EN
  logic [15:0]         underflow_cnt_q;
`endif

  // Reset assertion is immediate; release is delayed two rclk edges.
  always_ff @(posedge rclk_i or posedge reset_i) begin
    if (reset_i) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  assign rst_s = rst_sync_q[1];

  // Burst length and end-of-burst address/count arithmetic.
  always_comb begin
    line_left_s = 12'd0;
    burst_len_s = 9'd0;
    // A frame_start arriving together with the WAIT->REQ step sizes the
    // burst from the cleared line count.
    if (frame_start_i) begin
      line_left_s = LINE_WORDS_C;
    end else begin
      line_left_s = LINE_WORDS_C - line_cnt_q;
    end
    if (line_left_s < {3'b000, BURST_LEN_C}) begin
      burst_len_s = line_left_s[8:0];
    end else begin
      burst_len_s = BURST_LEN_C;
    end
    line_cnt_d = line_cnt_q + {3'b000, wr_len_q};
    // Address wraps silently at 2^ADDR_W.
    wr_addr_d  = wr_addr_q + ADDR_W'(wr_len_q);
  end

  // Read enable follows the live empty flag so a read is never issued into
  // an empty FIFO.
  assign fifo_ren_s = (state_q == S_BURST) && !fifo_rempty_i && (rem_q != 9'd0);

  // Main controller FSM with its registered outputs and counters.
  always_ff @(posedge rclk_i or posedge rst_s) begin
    if (rst_s) begin
      state_q     <= S_IDLE;
      wr_addr_q   <= '0;
      wr_len_q    <= 9'd0;
      rem_q       <= 9'd0;
      line_cnt_q  <= 12'd0;
      wr_req_q    <= 1'b0;
      wr_valid_q  <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      wr_valid_q  <= fifo_ren_s;
      line_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (frame_start_i) begin
            wr_addr_q  <= '0;
            line_cnt_q <= 12'd0;
          end
          if (en_i) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (frame_start_i) begin
            wr_addr_q  <= '0;
            line_cnt_q <= 12'd0;
          end
          if (!en_i) begin
            state_q <= S_IDLE;
          end else if (!fifo_prog_empty_i) begin
            state_q  <= S_REQ;
            wr_len_q <= burst_len_s;
            rem_q    <= burst_len_s;
            wr_req_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (wr_ack_i) begin
            state_q  <= S_BURST;
            wr_req_q <= 1'b0;
          end
        end
        S_BURST: begin
          if (fifo_ren_s) begin
            rem_q <= rem_q - 9'd1;
            if (rem_q == 9'd1) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // The final beat is on wr_valid during this cycle.
          wr_addr_q  <= wr_addr_d;
          line_cnt_q <= line_cnt_d;
          if (line_cnt_d == LINE_WORDS_C) begin
            state_q     <= S_LINE_END;
            line_done_q <= 1'b1;
          end else if (en_i) begin
            state_q <= S_WAIT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LINE_END: begin
          line_cnt_q <= 12'd0;
          if (en_i) begin
            state_q <= S_WAIT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          wr_req_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef RD_CTRL_UNDERFLOW_CNT_EN
  // Saturating count of burst cycles stalled on an empty FIFO.
  always_ff @(posedge rclk_i or posedge rst_s) begin
    if (rst_s) begin
      underflow_cnt_q <= 16'd0;
    end else if (frame_start_i) begin
      underflow_cnt_q <= 16'd0;
    end else if ((state_q == S_BURST) && (rem_q != 9'd0) && fifo_rempty_i &&
                 (underflow_cnt_q != 16'hFFFF)) begin
      underflow_cnt_q <= underflow_cnt_q + 16'd1;
    end
  end

  assign underflow_cnt_o = underflow_cnt_q;
`endif

  assign fifo_ren_o  = fifo_ren_s;
  assign wr_req_o    = wr_req_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_len_o    = wr_len_q;
  assign wr_data_o   = fifo_rdata_i;
  assign wr_valid_o  = wr_valid_q;
  assign line_done_o = line_done_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
// Scoreboard bench for fifo_burst_rd_ctrl (BURST_LEN=64, LINE_WORDS=480,
// ADDR_W=8 so addresses wrap). Stimulus pushes expected burst headers and data
// words into queues; a monitor on the falling edge pops and compares them.
module tb_fifo_burst_rd_ctrl;

  localparam int BL = 64;
  localparam int LW = 480;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          frame_start = 1'b0;
  logic [31:0]   fifo_rdata = 32'd0;
  logic          fifo_rempty;
  logic          fifo_prog_empty;
  logic          fifo_ren;
  logic          wr_req;
  logic          wr_ack = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [8:0]    wr_len;
  logic [31:0]   wr_data;
  logic          wr_valid;
  logic          line_done;
  logic          busy;
`ifdef RD_CTRL_UNDERFLOW_CNT_EN
  logic [15:0]   underflow_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // FIFO model: words are numbered, word n carries word_val(n).
  int   wr_cnt = 0;
  int   rd_cnt = 0;
  logic stall = 1'b0;
  logic ack_hold = 1'b0;

  logic [31:0]   exp_data[$];
  logic [AW-1:0] exp_addr[$];
  logic [8:0]    exp_len[$];

  int   beat_total = 0;
  int   beats = 0;
  int   prev_len = 0;
  logic have_prev = 1'b0;
  logic req_prev = 1'b0;
  int   lines_seen = 0;

  fifo_burst_rd_ctrl #(.BURST_LEN(BL), .LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .rclk_i(clk),
    .reset_i(reset),
    .en_i(en),
    .frame_start_i(frame_start),
    .fifo_rdata_i(fifo_rdata),
    .fifo_rempty_i(fifo_rempty),
    .fifo_prog_empty_i(fifo_prog_empty),
    .fifo_ren_o(fifo_ren),
    .wr_req_o(wr_req),
    .wr_ack_i(wr_ack),
    .wr_addr_o(wr_addr),
    .wr_len_o(wr_len),
    .wr_data_o(wr_data),
    .wr_valid_o(wr_valid),
    .line_done_o(line_done),
    .busy_o(busy)
`ifdef RD_CTRL_UNDERFLOW_CNT_EN
    ,
    .underflow_cnt_o(underflow_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_val(int n);
    return 32'hC0DE_0000 + 32'(n);
  endfunction

  assign fifo_rempty     = (wr_cnt == rd_cnt) || stall;
  assign fifo_prog_empty = (wr_cnt - rd_cnt) < 16;

  // FIFO read port: data appears the cycle after the read enable.
  always @(posedge clk) begin
    if (fifo_ren) begin
      fifo_rdata <= word_val(rd_cnt);
      rd_cnt     <= rd_cnt + 1;
    end
  end

  // pSRAM writer grant: ack one cycle after wr_req, unless held off.
  initial begin
    forever begin
      @(negedge clk);
      if (wr_ack) wr_ack = 1'b0;
      else if (wr_req && !ack_hold) wr_ack = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) exp_data.push_back(word_val(wr_cnt + i));
    wr_cnt = wr_cnt + n;
  endtask

  task automatic push_hdr(input int addr, input int len);
    exp_addr.push_back(AW'(addr));
    exp_len.push_back(9'(len));
  endtask

  // One full line of headers starting at word address base.
  task automatic push_line(input int base);
    for (int i = 0; i < 8; i++) push_hdr((base + 64 * i) % 256, (i < 7) ? 64 : 32);
  endtask

  // Monitor: protocol, data beats, burst headers and beat counts.
  always @(negedge clk) begin
    chk("ren_vs_req_or_empty", {31'd0, (fifo_ren && (wr_req || fifo_rempty || !busy))}, 32'd0);
    if (wr_valid) begin
      beat_total++;
      beats++;
      if (exp_data.size() == 0) chk("unexpected_beat", 32'd1, 32'd0);
      else chk("beat_data", wr_data, exp_data.pop_front());
    end
    if (line_done) lines_seen++;
    if (wr_req && !req_prev) begin
      if (have_prev) chk("burst_beats", beats, prev_len);
      if (exp_addr.size() == 0) begin
        chk("unexpected_req", 32'd1, 32'd0);
      end else begin
        prev_len = int'(exp_len[0]);
        chk("hdr_addr", {24'd0, wr_addr}, {24'd0, exp_addr.pop_front()});
        chk("hdr_len", {23'd0, wr_len}, {23'd0, exp_len.pop_front()});
      end
      beats = 0;
      have_prev = 1'b1;
    end
    req_prev = wr_req;
  end

  task automatic wait_rd(input int target, input int budget);
    int n = 0;
    while (rd_cnt < target && n < budget) begin @(negedge clk); n++; end
    chk("wait_rd_timeout", {31'd0, (rd_cnt < target)}, 32'd0);
  endtask

  task automatic wait_lines(input int target, input int budget);
    int n = 0;
    while (lines_seen < target && n < budget) begin @(negedge clk); n++; end
    chk("line_done_count", lines_seen, target);
  endtask

  initial begin
    int viol;
    int n;
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req", {31'd0, wr_req}, 32'd0);
    chk("rst_ren", {31'd0, fifo_ren}, 32'd0);
    chk("rst_valid", {31'd0, wr_valid}, 32'd0);
    chk("rst_addr", {24'd0, wr_addr}, 32'd0);
    chk("rst_len", {23'd0, wr_len}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_after_release", {31'd0, busy}, 32'd0);

    // Line 1: pre-filled FIFO, 7x64 + 1x32, addresses 0..448 mod 256.
    push_line(0);
    push_words(LW);
    en = 1'b1;
    wait_lines(1, 2000);

    // Line 2 with a 5-cycle empty stall inside its first burst.
    push_line(480);
    push_words(LW);
    wait_rd(490, 200);
    stall = 1'b1;
    repeat (5) begin
      #1 chk("stall_ren_low", {31'd0, fifo_ren}, 32'd0);
      @(negedge clk);
    end
    stall = 1'b0;
    #1 chk("stall_resume_ren", {31'd0, fifo_ren}, 32'd1);
`ifdef RD_CTRL_UNDERFLOW_CNT_EN
    chk("underflow_cnt", {16'd0, underflow_cnt}, 32'd5);
`endif
    wait_lines(2, 2000);

    // Grant withheld for 100 cycles, then en dropped during the next burst.
    ack_hold = 1'b1;
    push_hdr(960 % 256, 64);
    push_hdr(1024 % 256, 64);
    push_words(128);
    n = 0;
    while (!wr_req && n < 50) begin @(negedge clk); n++; end
    chk("req_seen", {31'd0, wr_req}, 32'd1);
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (!wr_req || fifo_ren) viol++;
    end
    chk("ack_hold_req_no_ren", viol, 0);
    ack_hold = 1'b0;
    wait_rd(1054, 400);
    en = 1'b0;
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    chk("idle_after_en_drop", {31'd0, busy}, 32'd0);
    chk("beats_drained", exp_data.size(), 0);
    chk("addr_after_wrap", {24'd0, wr_addr}, 32'd64);

    // frame_start in IDLE clears the address.
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    #1 chk("frame_start_addr", {24'd0, wr_addr}, 32'd0);
`ifdef RD_CTRL_UNDERFLOW_CNT_EN
    chk("frame_start_uf", {16'd0, underflow_cnt}, 32'd0);
`endif

    // Two bursts from address 0; reset at beat 20 of the second.
    push_hdr(0, 64);
    push_hdr(64, 64);
    push_words(128);
    en = 1'b1;
    n = 0;
    while (beat_total < 1172 && n < 400) begin @(negedge clk); n++; end
    chk("reach_beat20", {31'd0, (beat_total < 1172)}, 32'd0);
    chk("hdrs_consumed", exp_addr.size(), 0);
    #2 reset = 1'b1;
    exp_data.delete();
    @(negedge clk);
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ren", {31'd0, fifo_ren}, 32'd0);
    chk("mid_rst_req", {31'd0, wr_req}, 32'd0);
    chk("mid_rst_valid", {31'd0, wr_valid}, 32'd0);
    chk("mid_rst_line_done", {31'd0, line_done}, 32'd0);
    chk("mid_rst_addr", {24'd0, wr_addr}, 32'd0);
    chk("mid_rst_len", {23'd0, wr_len}, 32'd0);
    repeat (3) @(negedge clk);
    chk("lines_total", lines_seen, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_burst_rd_ctrl.md
FIFO_BURST_RD_CTRL -- requirements
Module: fifo_burst_rd_ctrl

Interface
REQ-001 Parameter BURST_LEN, default 64, words per write burst (1..256).
REQ-002 Parameter LINE_WORDS, default 480, 32-bit words per video line (≥1, <4096).
REQ-003 Parameter ADDR_W, default 24, width of the pSRAM word address.
REQ-004 Ports: rclk  input  1  sole clock; all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 en  input  1  level; run enable.
REQ-007 frame_start  input  1  pulse; clears the address and line counters.
REQ-008 fifo_rdata  input  32  FIFO read data, valid the cycle after fifo_ren.
REQ-009 fifo_rempty / fifo_prog_empty  input  1 each  FIFO empty / below-burst-threshold flags.
REQ-010 fifo_ren  output  1  FIFO read enable.
REQ-011 wr_req  output  1, wr_ack  input  1  burst request / grant handshake to the pSRAM writer.
REQ-012 wr_addr  output  ADDR_W  burst start address; wr_len  output  9  burst word count.
REQ-013 wr_data  output  32, wr_valid  output  1  burst data beat.
REQ-014 line_done  output  1  one-cycle pulse per completed line; busy  output  1  state≠IDLE.

Function
REQ-015 FSM states: IDLE, WAIT, REQ, BURST, DRAIN, LINE_END.
REQ-016 IDLE→WAIT when en=1; frame_start in IDLE or WAIT zeroes wr_addr and line word count next cycle; ignored in other states.
REQ-017 WAIT→IDLE if en=0; else WAIT→REQ when fifo_prog_empty=0.
REQ-018 On entry to REQ, latch wr_len = min(BURST_LEN, LINE_WORDS − line word count); wr_req=1 while in REQ.
REQ-019 REQ→BURST on the cycle wr_ack=1; wr_ack outside REQ is ignored.
REQ-020 In BURST, fifo_ren = (fifo_rempty=0) and (remaining read count≠0); each ren decrements remaining by 1.
REQ-021 fifo_rempty=1 mid-burst stalls reads (no ren) without leaving BURST; reads resume when it clears.
REQ-022 BURST→DRAIN on the cycle the last ren issues; DRAIN lasts exactly 1 cycle.
REQ-023 wr_valid = fifo_ren delayed 1 cycle; wr_data = fifo_rdata; exactly wr_len beats per burst.
REQ-024 At DRAIN exit, wr_addr += wr_len (modulo 2^ADDR_W, wraps silently) and line word count += wr_len.
REQ-025 DRAIN→LINE_END if line word count = LINE_WORDS, else →WAIT; en=0 during a burst completes the burst, then DRAIN→IDLE (LINE_END still taken if the line completed).
REQ-026 LINE_END lasts 1 cycle: line_done=1, line word count cleared, →WAIT (or IDLE if en=0).
REQ-027 wr_req and fifo_ren are never both asserted; no ren outside BURST.

Reset
REQ-028 reset=1 forces IDLE immediately; fifo_ren, wr_req, wr_valid, line_done=0; wr_addr, wr_len, counters=0; busy=0.
REQ-029 reset mid-burst abandons the burst; no further beats; FIFO contents are not flushed by this block.
REQ-030 Deassertion is synchronised internally to rclk (2-flop) before releasing state.

Configuration
REQ-031 Macro RD_CTRL_UNDERFLOW_CNT_EN defined: output underflow_cnt (16 bit) counts BURST cycles with remaining≠0 and fifo_rempty=1, saturating at 0xFFFF, cleared by reset and frame_start.
REQ-032 Macro undefined: port underflow_cnt and its logic are absent; all other behaviour identical.

Verification
REQ-033 LINE_WORDS=480, BURST_LEN=64, FIFO pre-filled, wr_ack 1 cycle after wr_req → 8 bursts (7×64 + 1×32), wr_addr 0,64,…,448, one line_done after burst 8.
REQ-034 Empty FIFO raised for 5 cycles mid-burst → ren gap of 5 cycles, burst still 64 beats, underflow_cnt=5 (macro on).
REQ-035 wr_ack held 0 for 100 cycles → wr_req stays 1, fifo_ren stays 0 throughout.
REQ-036 reset asserted at beat 20 of a burst → next cycle IDLE, all outputs 0, wr_addr=0.
REQ-037 ADDR_W=8, two lines of 480 words → wr_addr wraps modulo 256, no stall; en dropped mid-burst → burst finishes, FSM returns to IDLE.
